servo_pwm: RTL and testbench

//  Drives one hobby servo from the held/clamped joystick position (0..1023 scale).

---
 rtl/servo_pwm.sv | 100 ++++++++++
 tb/tb_servo_pwm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm.sv
// Hobby-servo PWM generator: clamps the held joystick position, maps it
// to a pulse width, slew-limits it per frame and emits a glitch-free pulse.
module servo_pwm #(
  parameter int unsigned CLKS_PER_FRAME = 500000,
  parameter int unsigned PULSE_MIN      = 25000,
  parameter int unsigned PULSE_MAX      = 50000,
  parameter int unsigned CYC_PER_COUNT  = 41,
  parameter int unsigned MIN_POS        = 228,
  parameter int unsigned MAX_POS        = 830,
  parameter int unsigned RESET_POS      = 529,
  parameter int unsigned MAX_STEP       = 2500
) (
  input  logic        CLK,
  input  logic        SW1,
  input  logic [31:0] i_pos,
  output logic        o_pwm,
  output logic        o_frame,
  output logic [19:0] o_width
);

  localparam logic [0:0]  GAP   = 1'b0;
  localparam logic [0:0]  PULSE = 1'b1;
  localparam logic [31:0] LAST  = 32'(CLKS_PER_FRAME - 1);
  localparam logic [19:0] STEP  = 20'(MAX_STEP);

  function automatic logic [31:0] clamp_pos(input logic [31:0] p);
    if (p < MIN_POS) return MIN_POS;
    if (p > MAX_POS) return MAX_POS;
    return p;
  endfunction

  // Callers pass clamped positions, so p - MIN_POS never wraps.
  function automatic logic [19:0] width_of(input logic [31:0] p);
    logic [31:0] w;
    w = PULSE_MIN + (p - MIN_POS) * CYC_PER_COUNT;
    if (w > PULSE_MAX) w = PULSE_MAX;
    return 20'(w);
  endfunction

  logic [31:0] s1;
  logic [19:0] t;
  logic [19:0] a;
  logic [19:0] a_next;
  logic [19:0] diff;
  logic        up;
  logic [31:0] cnt;
  logic [0:0]  state;

  assign o_pwm = (state == PULSE);

  // Two-stage target pipeline: clamp, then width mapping.
  always_ff @(posedge CLK) begin
    if (SW1) begin
      s1 <= 32'(RESET_POS);
      t  <= width_of(32'(RESET_POS));
    end else begin
      s1 <= clamp_pos(i_pos);
      t  <= width_of(s1);
    end
  end

  // Slew limiter: next applied width moves toward the target.
  always_comb begin
    up     = (t > a);
    diff   = up ? (t - a) : (a - t);
    a_next = t;
    if (MAX_STEP != 0 && {12'b0, diff} > MAX_STEP) begin
      a_next = up ? (a + STEP) : (a - STEP);
    end
  end

  // Applied width changes only on the last cycle of a frame.
  always_ff @(posedge CLK) begin
    if (SW1) begin
      a       <= width_of(32'(RESET_POS));
      o_width <= width_of(32'(RESET_POS));
    end else begin
      if (cnt == LAST) a <= a_next;
      o_width <= a;
    end
  end

  // Frame counter, frame strobe and PULSE/GAP state machine.
  always_ff @(posedge CLK) begin
    if (SW1) begin
      cnt     <= '0;
      o_frame <= 1'b0;
      state   <= GAP;
    end else begin
      cnt     <= (cnt == LAST) ? '0 : cnt + 32'd1;
      o_frame <= (cnt == '0);
      if (cnt == '0) begin
        state <= (a != '0) ? PULSE : GAP;
      end else if (state == PULSE && {12'b0, a} <= cnt) begin
        state <= GAP;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm.sv
// Directed bench for servo_pwm using scaled-down frame parameters
// so whole frames fit in a short run.
module tb_servo_pwm;

  localparam int CPF = 1000;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] ipos_a, ipos_b;
  logic        pwm_a, pwm_b, frm_a, frm_b;
  logic [19:0] wid_a, wid_b;
  logic        sel = 1'b0;

  logic        pwm_s, frm_s;
  logic [19:0] wid_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign pwm_s = sel ? pwm_b : pwm_a;
  assign frm_s = sel ? frm_b : frm_a;
  assign wid_s = sel ? wid_b : wid_a;

  servo_pwm #(
    .CLKS_PER_FRAME(CPF), .PULSE_MIN(100), .PULSE_MAX(650),
    .CYC_PER_COUNT(1), .MIN_POS(228), .MAX_POS(830),
    .RESET_POS(529), .MAX_STEP(100)
  ) u_a (
    .CLK(clk), .SW1(rst_a), .i_pos(ipos_a),
    .o_pwm(pwm_a), .o_frame(frm_a), .o_width(wid_a)
  );

  servo_pwm #(
    .CLKS_PER_FRAME(CPF), .PULSE_MIN(100), .PULSE_MAX(1200),
    .CYC_PER_COUNT(1), .MIN_POS(228), .MAX_POS(830),
    .RESET_POS(529), .MAX_STEP(0)
  ) u_b (
    .CLK(clk), .SW1(rst_b), .i_pos(ipos_b),
    .o_pwm(pwm_b), .o_frame(frm_b), .o_width(wid_b)
  );

  // Entered at the negedge of an o_frame cycle; leaves at the next one.
  task automatic meas(output int ow, output int hi,
                      output int per, output int runs);
    bit prev;
    ow = int'(wid_s); hi = 0; per = 0; runs = 0; prev = 1'b0;
    do begin
      if (pwm_s) begin
        hi++;
        if (!prev) runs++;
      end
      prev = pwm_s;
      per++;
      @(negedge clk);
    end while (!frm_s && per < 4 * CPF);
  endtask

  task automatic test_reset;
    int ow, hi, per, runs;
    repeat (2) @(negedge clk);
    checks++;
    if (pwm_a !== 1'b0) begin
      errors++; $display("FAIL rst_pwm got %0b want 0", pwm_a);
    end
    checks++;
    if (frm_a !== 1'b0) begin
      errors++; $display("FAIL rst_frame got %0b want 0", frm_a);
    end
    checks++;
    if (wid_a !== 20'd401) begin
      errors++; $display("FAIL rst_width got %0d want 401", wid_a);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    checks++;
    if (frm_a !== 1'b1 || pwm_a !== 1'b1) begin
      errors++;
      $display("FAIL rel_start frame %0b pwm %0b want 1 1", frm_a, pwm_a);
    end
    meas(ow, hi, per, runs);
    checks++;
    if (hi != 401 || per != CPF || runs != 1 || ow != 401) begin
      errors++;
      $display("FAIL frame0 hi %0d per %0d runs %0d ow %0d want 401 %0d 1 401",
               hi, per, runs, ow, CPF);
    end
  endtask

  task automatic test_slew;
    int e [5];
    int ow, hi, per, runs;
    e = '{401, 501, 601, 650, 650};
    ipos_a = 32'd830;
    for (int i = 0; i < 5; i++) begin
      meas(ow, hi, per, runs);
      checks++;
      if (hi != e[i] || ow != e[i] || per != CPF) begin
        errors++;
        $display("FAIL slew[%0d] hi %0d ow %0d per %0d want %0d", i, hi, ow, per, e[i]);
      end
    end
  endtask

  task automatic test_clamp;
    int dn [8];
    int upw [7];
    int ow, hi, per, runs;
    dn  = '{650, 550, 450, 350, 250, 150, 100, 100};
    upw = '{100, 200, 300, 400, 500, 600, 650};
    ipos_a = 32'd0;
    for (int i = 0; i < 8; i++) begin
      meas(ow, hi, per, runs);
      checks++;
      if (hi != dn[i] || ow != dn[i]) begin
        errors++;
        $display("FAIL clamp_lo[%0d] hi %0d ow %0d want %0d", i, hi, ow, dn[i]);
      end
    end
    ipos_a = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) begin
      meas(ow, hi, per, runs);
      checks++;
      if (hi != upw[i] || ow != upw[i]) begin
        errors++;
        $display("FAIL clamp_hi[%0d] hi %0d ow %0d want %0d", i, hi, ow, upw[i]);
      end
    end
  endtask

  task automatic test_midframe;
    int ow, hi, per, runs;
    fork
      meas(ow, hi, per, runs);
      begin
        repeat (50) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          ipos_a = (i % 2 == 0) ? 32'd228 : 32'd830;
          repeat (100) @(negedge clk);
        end
        ipos_a = 32'd830;
      end
    join
    checks++;
    if (hi != 650 || runs != 1 || ow != 650) begin
      errors++;
      $display("FAIL midframe hi %0d runs %0d ow %0d want 650 1 650", hi, runs, ow);
    end
    meas(ow, hi, per, runs);
    checks++;
    if (hi != 650 || runs != 1) begin
      errors++;
      $display("FAIL midframe_next hi %0d runs %0d want 650 1", hi, runs);
    end
  endtask

  task automatic test_reset_midpulse;
    int ow, hi, per, runs;
    repeat (200) @(negedge clk);
    checks++;
    if (pwm_a !== 1'b1) begin
      errors++; $display("FAIL pre_rst_pwm got %0b want 1", pwm_a);
    end
    ipos_a = 32'd529;
    rst_a = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm_a !== 1'b0 || frm_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst pwm %0b frame %0b want 0 0", pwm_a, frm_a);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wid_a !== 20'd401 || pwm_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hold width %0d pwm %0b want 401 0", wid_a, pwm_a);
    end
    rst_a = 1'b0;
    @(negedge clk);
    checks++;
    if (frm_a !== 1'b1 || pwm_a !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rel frame %0b pwm %0b want 1 1", frm_a, pwm_a);
    end
    meas(ow, hi, per, runs);
    checks++;
    if (hi != 401 || per != CPF || runs != 1 || ow != 401) begin
      errors++;
      $display("FAIL midrst_frame hi %0d per %0d runs %0d ow %0d want 401 %0d 1 401",
               hi, per, runs, ow, CPF);
    end
  endtask

  task automatic test_no_limit;
    int ow, hi, per, runs;
    int n;
    sel = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frm_b && n < 2 * CPF);
    checks++;
    if (!frm_b) begin
      errors++; $display("FAIL nolim_sync got no frame within %0d cycles", n);
    end
    ipos_b = 32'd830;
    meas(ow, hi, per, runs);
    checks++;
    if (hi != 100 || ow != 100) begin
      errors++; $display("FAIL nolim_low hi %0d ow %0d want 100", hi, ow);
    end
    meas(ow, hi, per, runs);
    checks++;
    if (hi != 702 || ow != 702 || per != CPF) begin
      errors++;
      $display("FAIL nolim_jump hi %0d ow %0d per %0d want 702 702 %0d", hi, ow, per, CPF);
    end
    sel = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ipos_a = 32'd529; ipos_b = 32'd228;
    test_reset;
    test_slew;
    test_clamp;
    test_midframe;
    test_reset_midpulse;
    test_no_limit;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
